// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int BIN_W  = 8;
   localparam int BCD_W  = 18;
   localparam int N_ITER = 8;

   localparam logic [3:0] ADD3_THRESH = 4'd4;
   localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_dd_step.sv
// One shift-add-3 iteration on the work word: {hundreds[1:0], tens, units, binary[7:0]}.
module bcd_dd_step
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] work,
   output logic [BCD_W-1:0] stepped
);

   logic [BCD_W-1:0] adj;

   // Hundreds never exceed 2 for an 8-bit input, so only units and tens need correcting.
   always_comb begin
      adj = work;
      if (work[11:8] > ADD3_THRESH) adj[11:8] = work[11:8] + ADD3_VAL;
      if (work[15:12] > ADD3_THRESH) adj[15:12] = work[15:12] + ADD3_VAL;
      stepped = {adj[BCD_W-2:0], 1'b0};
   end

endmodule

// File: rtl/bcd_share_ctrl.sv
// Round-robin front end, iteration FSM and result registers around one shared BCD step.
module bcd_share_ctrl
   import bcd_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*BIN_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ID_W-1:0]        out_id,
   output logic [1:0]             hundred,
   output logic [3:0]             decade,
   output logic [3:0]             unit
);

   localparam int CNT_W = $clog2(N_ITER);

   state_t           state, state_nxt;
   logic [BCD_W-1:0] work, work_step;
   logic [CNT_W-1:0] count;
   logic [ID_W-1:0]  last_grant, grant_idx;
   logic             grant_any, accept, last_iter;
   logic [BIN_W-1:0] grant_data;

   bcd_dd_step u_step (
      .work    (work),
      .stepped (work_step)
   );

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin : arbiter
      int unsigned idx;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned off = 1; off <= unsigned'(N_REQ); off++) begin
         idx = 32'(last_grant) + off;
         if (idx >= unsigned'(N_REQ)) idx = idx - unsigned'(N_REQ);
         if (!grant_any && req_valid[ID_W'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   assign grant_data = req_data[32'(grant_idx)*BIN_W +: BIN_W];
   assign accept     = (state == IDLE) && en && grant_any;
   assign last_iter  = (count == CNT_W'(N_ITER - 1));

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (last_iter) state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Digits are captured from the final step output so they are valid on DONE entry.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         work       <= '0;
         count      <= '0;
         last_grant <= ID_W'(N_REQ - 1);
         out_id     <= '0;
         out_valid  <= 1'b0;
         hundred    <= '0;
         decade     <= '0;
         unit       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work       <= {{(BCD_W-BIN_W){1'b0}}, grant_data};
                  count      <= '0;
                  out_id     <= grant_idx;
                  last_grant <= grant_idx;
               end
            end
            SHIFT: begin
               work <= work_step;
               if (last_iter) begin
                  out_valid <= 1'b1;
                  hundred   <= work_step[17:16];
                  decade    <= work_step[15:12];
                  unit      <= work_step[11:8];
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_share_ctrl.sv
// Directed bench for bcd_share_ctrl with a cycle-level behavioural reference model.
module tb_bcd_share_ctrl;

   localparam int N_REQ = 2;
   localparam int ID_W  = 1;

   typedef struct {
      int id;
      int h;
      int d;
      int u;
   } res_t;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             en = 1'b0;
   logic [N_REQ-1:0] req_valid = '0;
   logic [15:0]      req_data = '0;
   logic [N_REQ-1:0] req_ready;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ID_W-1:0]  out_id;
   logic [1:0]       hundred;
   logic [3:0]       decade;
   logic [3:0]       unit;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_share_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .en        (en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .hundred   (hundred),
      .decade    (decade),
      .unit      (unit)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_idle  = 1'b1;
   bit m_valid = 1'b0;
   int m_since = 0;
   int m_last  = N_REQ - 1;
   int m_id    = 0;
   int m_val   = 0;
   int m_h     = 0;
   int m_d     = 0;
   int m_u     = 0;
   int m_g;

   function automatic int pick(input logic [N_REQ-1:0] v, input int last);
      for (int off = 1; off <= N_REQ; off++) begin
         if (v[(last + off) % N_REQ]) return (last + off) % N_REQ;
      end
      return -1;
   endfunction

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_idle = 1'b1; m_valid = 1'b0; m_since = 0; m_last = N_REQ - 1;
         m_id = 0; m_val = 0; m_h = 0; m_d = 0; m_u = 0;
      end else if (m_idle) begin
         m_g = pick(req_valid, m_last);
         if (en && m_g >= 0) begin
            m_val  = int'((req_data >> (8 * m_g)) & 16'hff);
            m_id   = m_g;
            m_last = m_g;
            m_since = 0;
            m_idle = 1'b0;
         end
      end else if (!m_valid) begin
         m_since++;
         if (m_since == 8) begin
            m_valid = 1'b1;
            m_h = m_val / 100;
            m_d = (m_val / 10) % 10;
            m_u = m_val % 10;
         end
      end else if (out_ready) begin
         m_valid = 1'b0;
         m_idle  = 1'b1;
      end
   end

   // ---------------- compare and monitor ----------------
   int   cyc = 0;
   int   acc_cyc = 0, val_cyc = 0, hs_cyc = 0, valid_seen = 0;
   bit   prev_valid = 1'b0;
   int   grant_q[$];
   res_t res_q[$];
   int   e_g, e_ready;

   always @(negedge sys_clk) begin
      cyc++;
      e_g     = (m_idle && en) ? pick(req_valid, m_last) : -1;
      e_ready = (e_g >= 0) ? (1 << e_g) : 0;
      chk("req_ready", int'(req_ready), e_ready);
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_id", int'(out_id), m_id);
      chk("hundred", int'(hundred), m_h);
      chk("decade", int'(decade), m_d);
      chk("unit", int'(unit), m_u);
      if (|req_ready) begin
         grant_q.push_back(req_ready[1] ? 1 : 0);
         acc_cyc = cyc;
      end
      if (out_valid && !prev_valid) val_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
         res_q.push_back('{int'(out_id), int'(hundred), int'(decade), int'(unit)});
         hs_cyc = cyc;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_grants(input int n);
      int k = 0;
      while (grant_q.size() < n && k < 200) begin
         @(posedge sys_clk); #1; k++;
      end
      if (grant_q.size() < n) chk("grant_timeout", grant_q.size(), n);
   endtask

   task automatic wait_results(input int n);
      int k = 0;
      while (res_q.size() < n && k < 300) begin
         @(posedge sys_clk); #1; k++;
      end
      if (res_q.size() < n) chk("result_timeout", res_q.size(), n);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!out_valid && k < 50) begin
         @(posedge sys_clk); #1; k++;
      end
      if (!out_valid) chk("valid_timeout", 0, 1);
   endtask

   task automatic request(input int id, input int d);
      int n0 = grant_q.size();
      req_data[8*id +: 8] = 8'(d);
      req_valid[id] = 1'b1;
      wait_grants(n0 + 1);
      req_valid[id] = 1'b0;
   endtask

   task automatic chk_res(input string name, input int idx, input int id, input int h,
                          input int d, input int u);
      if (idx >= res_q.size()) begin
         chk({name, "_missing"}, res_q.size(), idx + 1);
      end else begin
         chk({name, "_id"}, res_q[idx].id, id);
         chk({name, "_h"}, res_q[idx].h, h);
         chk({name, "_d"}, res_q[idx].d, d);
         chk({name, "_u"}, res_q[idx].u, u);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int vals[5]  = '{0, 9, 99, 100, 128};
      int exp_h[5] = '{0, 0, 0, 1, 1};
      int exp_d[5] = '{0, 0, 9, 0, 2};
      int exp_u[5] = '{0, 9, 9, 0, 8};
      int n0, r0, vs0;

      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_out_id", int'(out_id), 0);
      chk("rst_digits", int'({hundred, decade, unit}), 0);
      sys_rst = 1'b0;
      en = 1'b1;

      // 255 -> 2/5/5 on requester 0, nine cycles after the accept cycle
      request(0, 255);
      wait_results(1);
      chk_res("t1", 0, 0, 2, 5, 5);
      chk("t1_latency", val_cyc - acc_cyc, 9);

      for (int i = 0; i < 5; i++) begin
         request(1, vals[i]);
         wait_results(2 + i);
         chk_res("t2", 1 + i, 1, exp_h[i], exp_d[i], exp_u[i]);
      end

      // both requesters continuously valid: alternating grants
      n0 = grant_q.size();
      r0 = res_q.size();
      req_data  = {8'd200, 8'd12};
      req_valid = 2'b11;
      wait_grants(n0 + 4);
      req_valid = 2'b00;
      wait_results(r0 + 4);
      for (int k = 0; k < 4; k++) begin
         if (n0 + k < grant_q.size()) chk("t3_grant", grant_q[n0 + k], k % 2);
         if (k % 2 == 0) chk_res("t3_even", r0 + k, 0, 0, 1, 2);
         else            chk_res("t3_odd", r0 + k, 1, 2, 0, 0);
      end

      // consumer back-pressure for 20 cycles
      out_ready = 1'b0;
      n0 = grant_q.size();
      r0 = res_q.size();
      req_data  = {8'd88, 8'd57};
      req_valid = 2'b01;
      wait_grants(n0 + 1);
      req_valid = 2'b10;
      wait_valid();
      repeat (20) begin @(posedge sys_clk); #1; end
      chk("t4_held_valid", int'(out_valid), 1);
      chk("t4_held_digits", int'({hundred, decade, unit}), int'({2'd0, 4'd5, 4'd7}));
      chk("t4_no_grant", grant_q.size(), n0 + 1);
      out_ready = 1'b1;
      wait_grants(n0 + 2);
      req_valid = 2'b00;
      chk("t4_gap", acc_cyc - hs_cyc, 1);
      if (n0 + 1 < grant_q.size()) chk("t4_grant", grant_q[n0 + 1], 1);
      wait_results(r0 + 2);
      chk_res("t4_a", r0, 0, 0, 5, 7);
      chk_res("t4_b", r0 + 1, 1, 0, 8, 8);

      // en gates grants only
      en = 1'b0;
      n0 = grant_q.size();
      r0 = res_q.size();
      req_data  = {8'd45, 8'd250};
      req_valid = 2'b11;
      repeat (30) begin @(posedge sys_clk); #1; end
      chk("t5_blocked", grant_q.size(), n0);
      en = 1'b1;
      wait_grants(n0 + 1);
      repeat (3) begin @(posedge sys_clk); #1; end
      en = 1'b0;
      wait_results(r0 + 1);
      chk("t5_latency", val_cyc - acc_cyc, 9);
      chk_res("t5", r0, 0, 2, 5, 0);
      repeat (10) begin @(posedge sys_clk); #1; end
      chk("t5_still_blocked", grant_q.size(), n0 + 1);
      req_valid = 2'b00;
      en = 1'b1;

      // asynchronous reset mid-conversion
      r0 = res_q.size();
      request(0, 77);
      repeat (4) @(posedge sys_clk);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_id", int'(out_id), 0);
      chk("t6_rst_digits", int'({hundred, decade, unit}), 0);
      chk("t6_rst_ready", int'(req_ready), 0);
      vs0 = valid_seen;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      repeat (15) begin @(posedge sys_clk); #1; end
      chk("t6_no_valid", valid_seen, vs0);
      chk("t6_no_result", res_q.size(), r0);
      n0 = grant_q.size();
      req_data  = {8'd1, 8'd2};
      req_valid = 2'b11;
      wait_grants(n0 + 1);
      req_valid = 2'b00;
      if (n0 < grant_q.size()) chk("t6_first_grant", grant_q[n0], 0);
      wait_results(r0 + 1);
      chk_res("t6", r0, 0, 0, 0, 2);

      repeat (3) begin @(posedge sys_clk); #1; end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
